hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the combinational hazard/forwarding logic for the MIPS core.
//  Tracks pending register writes with per-register latency countdowns, so variable-latency
//  producers (ALU=0, load=1, MUL/DIV=N) stall dependents for exactly the right number of cycles.
//  Also produces EX-stage forwarding selects from three sources: MEM, WB and the long-latency port.
//  Sits beside the ID/EX pipeline registers and drives the IF/ID stall and the EX operand muxes.
// PARAMETERS
//  NUM_REGS  32  architectural registers; register 0 is never pending
//  REG_AW     5  register index width, log2(NUM_REGS)
//  LAT_W      3  countdown width; maximum stall latency = 2**LAT_W-1
// PORTS
//  clk            in   1       core clock
//  rst            in   1       asynchronous reset, active-high
//  id_valid       in   1       ID holds a valid instruction
//  id_rs, id_rt   in   REG_AW  ID source registers
//  id_needs_rs/rt in   1       ID consumes rs/rt at the end of ID or in EX
//  id_rd          in   REG_AW  ID destination register
//  id_regw        in   1       ID instruction writes id_rd
//  id_lat         in   LAT_W   stall cycles an immediately following dependent needs
//  flush          in   1       kill the ID instruction this cycle (branch/exception)
//  ex_stall_in    in   1       downstream stall request; ORed into id_stall
//  ex_rs, ex_rt   in   REG_AW  EX source registers
//  ex_wants_rs/rt in   1       EX reads rs/rt through the forwarding muxes
//  mem_rd/mem_regw  in REG_AW/1  MEM-stage writer
//  wb_rd/wb_regw    in REG_AW/1  WB-stage writer
//  lw_rd/lw_regw    in REG_AW/1  long-latency unit write-back port
//  ex_fwd_rs_sel  out  2       00 regfile, 01 MEM, 10 WB, 11 long-latency port
//  ex_fwd_rt_sel  out  2       same encoding as ex_fwd_rs_sel
//  id_stall       out  1       hold the ID stage
//  if_stall       out  1       equal to id_stall
//  stall_cycles   out  32      performance counter (see CONFIGURATION)
// BEHAVIOUR
//  - State: pend_cnt[r], LAT_W bits, r = 1..NUM_REGS-1. pend_cnt[0] is constant 0.
//  - Reset (async): all pend_cnt = 0 and stall_cycles = 0. Outputs then follow the inputs
//    combinationally; with no active match they are 0.
//  - Hazards:
//    - rs_hz = id_needs_rs & id_rs!=0 & pend_cnt[id_rs]!=0; rt_hz is the same for rt.
//    - waw_hz = id_regw & id_rd!=0 & pend_cnt[id_rd] > id_lat. The newer write must not
//      complete before the older one.
//  - id_stall = id_valid & (rs_hz|rt_hz|waw_hz) | ex_stall_in. This is combinational, with
//    0-cycle latency from the counters.
//  - id_fire = id_valid & ~id_stall & ~flush.
//  - Per clock, for each r: if id_fire & id_regw & id_rd==r & id_lat!=0, pend_cnt[r] <= id_lat.
//    Otherwise, if pend_cnt[r]!=0, pend_cnt[r] <= pend_cnt[r]-1.
//    Issue takes priority over decrement on the same register.
//  - id_lat==0 creates no entry; the ALU result is forwarded.
//  - Counters decrement during stalls, so stalls are bounded by id_lat.
//  - flush suppresses issue only. Existing counters keep counting; the extra stalls are
//    conservative and acceptable.
//  - Forwarding for rs (rt is identical):
//    - mem_m = ex_wants_rs & ex_rs!=0 & mem_regw & mem_rd==ex_rs; wb_m and lw_m are analogous.
//    - Priority is MEM > WB > LW: sel = mem_m ? 01 : wb_m ? 10 : lw_m ? 11 : 00.
//  - Counters saturate at 0 and never wrap below 0.
//  - rst mid-stall: id_stall drops immediately if no other cause is active.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//    - stall_cycles increments by 1 on each clock where id_valid & id_stall & ~ex_stall_in.
//    - It saturates at 32'hFFFF_FFFF and is cleared by rst.
//  HAZ_PERF_CNT_EN undefined: stall_cycles is tied to 32'd0 and no counter flops exist.
// TESTING
//  1. Load-use: issue rd=5, id_lat=1, then rs=5 needed -> id_stall=1 for exactly 1 cycle,
//     then ex_fwd_rs_sel=10 when the load is in WB.
//  2. MUL: issue rd=9, id_lat=3, then rt=9 needed -> id_stall=1 for 3 cycles, then deasserts;
//     with HAZ_PERF_CNT_EN, stall_cycles=3.
//  3. r0 and ALU: issue rd=0 with id_lat=4, or rd=6 with id_lat=0, then a dependent ->
//     id_stall=0 in both cases.
//  4. Forwarding priority: ex_rs=7 with mem_rd=wb_rd=lw_rd=7, all regw=1 -> sel=01.
//     Drop mem_regw -> 10. Drop wb_regw -> 11.
//  5. WAW: pend_cnt[4]=3, then ID writes rd=4 with id_lat=1 -> id_stall until pend_cnt[4]<=1,
//     then issue sets pend_cnt[4]=1.
//  6. Reset mid-op: pend_cnt[8]=5 with a dependent stalled; pulse rst asynchronously ->
//     id_stall=0 before the next edge and all counters=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID/EX pipeline and hazard_scoreboard: ID issue info, EX forwarding
// requests, writer tags from MEM/WB/long-latency, and stall/forward-select results.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_needs_rs, id_needs_rt, id_regw;
    logic [LAT_W-1:0]  id_lat;
    logic              flush, ex_stall_in;
    logic [REG_AW-1:0] ex_rs, ex_rt;
    logic              ex_wants_rs, ex_wants_rt;
    logic [REG_AW-1:0] mem_rd, wb_rd, lw_rd;
    logic              mem_regw, wb_regw, lw_regw;
    logic [1:0]        ex_fwd_rs_sel, ex_fwd_rt_sel;
    logic              id_stall, if_stall;
    logic [31:0]       stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_needs_rs, id_needs_rt, id_regw, id_lat,
               flush, ex_stall_in, ex_rs, ex_rt, ex_wants_rs, ex_wants_rt,
               mem_rd, wb_rd, lw_rd, mem_regw, wb_regw, lw_regw,
        input  ex_fwd_rs_sel, ex_fwd_rt_sel, id_stall, if_stall, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_needs_rs, id_needs_rt, id_regw, id_lat,
               flush, ex_stall_in, ex_rs, ex_rt, ex_wants_rs, ex_wants_rt,
               mem_rd, wb_rd, lw_rd, mem_regw, wb_regw, lw_regw,
        output ex_fwd_rs_sel, ex_fwd_rt_sel, id_stall, if_stall, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write countdowns drive the ID stall; EX forwarding selects from MEM/WB/LW.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module hz_pend_cnt #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);
    // Issue wins over the decrement; an idle counter sits at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt <= '0;
        else if (load)           cnt <= load_val;
        else if (cnt != '0)      cnt <= cnt - LAT_W'(1);
    end
endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave bus
);
    logic [NUM_REGS-1:0][LAT_W-1:0] pend_cnt;
    logic rs_hz, rt_hz, waw_hz, id_fire, issue;

    assign rs_hz  = bus.id_needs_rs && (bus.id_rs != '0) && (pend_cnt[bus.id_rs] != '0);
    assign rt_hz  = bus.id_needs_rt && (bus.id_rt != '0) && (pend_cnt[bus.id_rt] != '0);
    // A newer write must not land before an older, longer-latency write to the same register.
    assign waw_hz = bus.id_regw && (bus.id_rd != '0) && (pend_cnt[bus.id_rd] > bus.id_lat);

    assign bus.id_stall = (bus.id_valid && (rs_hz || rt_hz || waw_hz)) || bus.ex_stall_in;
    assign bus.if_stall = bus.id_stall;

    assign id_fire = bus.id_valid && !bus.id_stall && !bus.flush;
    assign issue   = id_fire && bus.id_regw && (bus.id_lat != '0);

    assign pend_cnt[0] = '0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
            hz_pend_cnt #(.LAT_W(LAT_W)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (issue && (bus.id_rd == REG_AW'(r))),
                .load_val (bus.id_lat),
                .cnt      (pend_cnt[r])
            );
        end
    endgenerate

    function automatic logic [1:0] fwd_sel(
        input logic              want,
        input logic [REG_AW-1:0] src,
        input logic              m_w, input logic [REG_AW-1:0] m_rd,
        input logic              w_w, input logic [REG_AW-1:0] w_rd,
        input logic              l_w, input logic [REG_AW-1:0] l_rd
    );
        if (!want || src == '0)       return 2'b00;
        if (m_w && m_rd == src)       return 2'b01;
        if (w_w && w_rd == src)       return 2'b10;
        if (l_w && l_rd == src)       return 2'b11;
        return 2'b00;
    endfunction

    assign bus.ex_fwd_rs_sel = fwd_sel(bus.ex_wants_rs, bus.ex_rs,
                                       bus.mem_regw, bus.mem_rd, bus.wb_regw, bus.wb_rd,
                                       bus.lw_regw, bus.lw_rd);
    assign bus.ex_fwd_rt_sel = fwd_sel(bus.ex_wants_rt, bus.ex_rt,
                                       bus.mem_regw, bus.mem_rd, bus.wb_regw, bus.wb_rd,
                                       bus.lw_regw, bus.lw_rd);

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts only hazard-induced stalls; downstream back-pressure is excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (bus.id_valid && bus.id_stall && !bus.ex_stall_in && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_cycles = stall_cnt_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic checked against a cycles-remaining model of
// pending register writes.
module tb_hazard_scoreboard;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pend[NR];
    bit [31:0] perf;

    hazard_scoreboard_if #(.REG_AW(5), .LAT_W(3)) bus();

    hazard_scoreboard #(.NUM_REGS(NR), .REG_AW(5), .LAT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic bit m_stall();
        bit hz;
        hz = (bus.id_needs_rs && bus.id_rs != 0 && pend[bus.id_rs] != 0) ||
             (bus.id_needs_rt && bus.id_rt != 0 && pend[bus.id_rt] != 0) ||
             (bus.id_regw && bus.id_rd != 0 && pend[bus.id_rd] > int'(bus.id_lat));
        return (bus.id_valid && hz) || bus.ex_stall_in;
    endfunction

    function automatic logic [1:0] m_sel(bit want, int src);
        if (!want || src == 0) return 2'b00;
        if (bus.mem_regw && int'(bus.mem_rd) == src) return 2'b01;
        if (bus.wb_regw  && int'(bus.wb_rd)  == src) return 2'b10;
        if (bus.lw_regw  && int'(bus.lw_rd)  == src) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit [31:0] exp_perf();
`ifdef HAZ_PERF_CNT_EN
        return perf;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) pend[r] = 0;
        perf = 0;
    endtask

    // Advance the model with the current inputs, then let the DUT take the same edge.
    task automatic tick();
        bit st, fire;
        st   = m_stall();
        fire = bus.id_valid && !st && !bus.flush;
        if (bus.id_valid && st && !bus.ex_stall_in && perf != 32'hFFFF_FFFF) perf++;
        for (int r = 1; r < NR; r++) begin
            if (fire && bus.id_regw && int'(bus.id_rd) == r && bus.id_lat != 0) pend[r] = int'(bus.id_lat);
            else if (pend[r] > 0) pend[r]--;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_needs_rs = 0; bus.id_needs_rt = 0; bus.id_regw = 0; bus.id_lat = 0;
        bus.flush = 0; bus.ex_stall_in = 0; bus.ex_rs = 0; bus.ex_rt = 0;
        bus.ex_wants_rs = 0; bus.ex_wants_rt = 0;
        bus.mem_rd = 0; bus.wb_rd = 0; bus.lw_rd = 0;
        bus.mem_regw = 0; bus.wb_regw = 0; bus.lw_regw = 0;
    endtask

    task automatic set_id(bit v, int rd, bit regw, int lat, int rs, bit nrs, int rt, bit nrt);
        bus.id_valid = v; bus.id_rd = 5'(rd); bus.id_regw = regw; bus.id_lat = 3'(lat);
        bus.id_rs = 5'(rs); bus.id_needs_rs = nrs; bus.id_rt = 5'(rt); bus.id_needs_rt = nrt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        @(posedge clk); #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.id_stall); end
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL reset_if_stall: got %b want 0", bus.if_stall); end
        checks++; if (bus.ex_fwd_rs_sel !== 2'b00 || bus.ex_fwd_rt_sel !== 2'b00) begin
            errors++; $display("FAIL reset_sel: got %b/%b want 00/00", bus.ex_fwd_rs_sel, bus.ex_fwd_rt_sel); end
        checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", bus.stall_cycles); end
        bus.ex_stall_in = 1'b1; #1;
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL reset_ex_stall_in: got %b want 1", bus.id_stall); end
        bus.ex_stall_in = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        idle();
        set_id(1, 5, 1, 1, 0, 0, 0, 0); #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL load_issue: got %b want 0", bus.id_stall); end
        tick();
        set_id(1, 0, 0, 0, 5, 1, 0, 0); #1;
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", bus.id_stall); end
        tick();
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b want 0", bus.id_stall); end
        tick();
        idle();
        bus.ex_rs = 5; bus.ex_wants_rs = 1; bus.wb_rd = 5; bus.wb_regw = 1; #1;
        checks++; if (bus.ex_fwd_rs_sel !== 2'b10) begin errors++; $display("FAIL load_use_fwd: got %b want 10", bus.ex_fwd_rs_sel); end
        idle();
    endtask

    task automatic test_mul();
        int n;
        idle();
        set_id(1, 9, 1, 3, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 9, 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.id_stall !== 1'b1) break;
            n++;
            tick();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL mul_stall_len: got %0d cycles want 3", n); end
        checks++; if (bus.stall_cycles !== exp_perf()) begin
            errors++; $display("FAIL mul_perf: got %0d want %0d", bus.stall_cycles, exp_perf()); end
        tick();
        idle();
    endtask

    task automatic test_r0_alu();
        idle();
        set_id(1, 0, 1, 4, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 0, 1); #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL r0_dep: got %b want 0", bus.id_stall); end
        set_id(1, 6, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 6, 1, 6, 1); #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL alu_dep: got %b want 0", bus.id_stall); end
        tick();
        idle();
    endtask

    task automatic test_fwd_priority();
        idle();
        bus.ex_rs = 7; bus.ex_rt = 7; bus.ex_wants_rs = 1; bus.ex_wants_rt = 1;
        bus.mem_rd = 7; bus.wb_rd = 7; bus.lw_rd = 7;
        bus.mem_regw = 1; bus.wb_regw = 1; bus.lw_regw = 1; #1;
        checks++; if (bus.ex_fwd_rs_sel !== 2'b01) begin errors++; $display("FAIL fwd_mem: got %b want 01", bus.ex_fwd_rs_sel); end
        checks++; if (bus.ex_fwd_rt_sel !== 2'b01) begin errors++; $display("FAIL fwd_mem_rt: got %b want 01", bus.ex_fwd_rt_sel); end
        bus.mem_regw = 0; #1;
        checks++; if (bus.ex_fwd_rs_sel !== 2'b10) begin errors++; $display("FAIL fwd_wb: got %b want 10", bus.ex_fwd_rs_sel); end
        bus.wb_regw = 0; #1;
        checks++; if (bus.ex_fwd_rs_sel !== 2'b11) begin errors++; $display("FAIL fwd_lw: got %b want 11", bus.ex_fwd_rs_sel); end
        checks++; if (bus.ex_fwd_rt_sel !== 2'b11) begin errors++; $display("FAIL fwd_lw_rt: got %b want 11", bus.ex_fwd_rt_sel); end
        bus.ex_wants_rs = 0; #1;
        checks++; if (bus.ex_fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL fwd_nowant: got %b want 00", bus.ex_fwd_rs_sel); end
        bus.ex_wants_rs = 1; bus.ex_rs = 0; bus.mem_rd = 0; bus.mem_regw = 1; #1;
        checks++; if (bus.ex_fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b want 00", bus.ex_fwd_rs_sel); end
        idle();
    endtask

    task automatic test_waw();
        idle();
        set_id(1, 4, 1, 3, 0, 0, 0, 0);
        tick();
        set_id(1, 4, 1, 1, 0, 0, 0, 0); #1;
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL waw_cnt3: got %b want 1", bus.id_stall); end
        tick();
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL waw_cnt2: got %b want 1", bus.id_stall); end
        tick();
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL waw_cnt1: got %b want 0", bus.id_stall); end
        tick();
        set_id(1, 0, 0, 0, 4, 1, 0, 0); #1;
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL waw_reissue: got %b want 1", bus.id_stall); end
        tick();
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL waw_drain: got %b want 0", bus.id_stall); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        int bad;
        idle();
        set_id(1, 8, 1, 5, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 8, 1, 0, 0); #1;
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", bus.id_stall); end
        #1 rst = 1'b1; #1;
        model_reset();
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL rstmid_async: got %b want 0", bus.id_stall); end
        checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("FAIL rstmid_perf: got %0d want 0", bus.stall_cycles); end
        rst = 1'b0;
        bad = 0;
        for (int r = 1; r < NR; r++) begin
            set_id(1, 0, 0, 0, r, 1, r, 1); #1;
            if (bus.id_stall !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_counters: %0d registers still pending, want 0", bad); end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [1:0] ers, ert;
        idle();
        for (int c = 0; c < 600; c++) begin
            bus.id_valid    = ($urandom_range(0, 3) != 0);
            bus.id_rs       = 5'($urandom_range(0, 7));
            bus.id_rt       = 5'($urandom_range(0, 7));
            bus.id_rd       = 5'($urandom_range(0, 7));
            bus.id_needs_rs = 1'($urandom_range(0, 1));
            bus.id_needs_rt = 1'($urandom_range(0, 1));
            bus.id_regw     = 1'($urandom_range(0, 1));
            bus.id_lat      = 3'($urandom_range(0, 7));
            bus.flush       = ($urandom_range(0, 7) == 0);
            bus.ex_stall_in = ($urandom_range(0, 9) == 0);
            bus.ex_rs       = 5'($urandom_range(0, 7));
            bus.ex_rt       = 5'($urandom_range(0, 7));
            bus.ex_wants_rs = 1'($urandom_range(0, 1));
            bus.ex_wants_rt = 1'($urandom_range(0, 1));
            bus.mem_rd      = 5'($urandom_range(0, 7));
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.lw_rd       = 5'($urandom_range(0, 7));
            bus.mem_regw    = 1'($urandom_range(0, 1));
            bus.wb_regw     = 1'($urandom_range(0, 1));
            bus.lw_regw     = 1'($urandom_range(0, 1));
            #1;
            ers = m_sel(bus.ex_wants_rs, int'(bus.ex_rs));
            ert = m_sel(bus.ex_wants_rt, int'(bus.ex_rt));
            checks++; if (bus.id_stall !== m_stall()) begin
                errors++; $display("FAIL rand_stall c=%0d: got %b want %b", c, bus.id_stall, m_stall()); end
            checks++; if (bus.if_stall !== m_stall()) begin
                errors++; $display("FAIL rand_if_stall c=%0d: got %b want %b", c, bus.if_stall, m_stall()); end
            checks++; if (bus.ex_fwd_rs_sel !== ers) begin
                errors++; $display("FAIL rand_rs_sel c=%0d: got %b want %b", c, bus.ex_fwd_rs_sel, ers); end
            checks++; if (bus.ex_fwd_rt_sel !== ert) begin
                errors++; $display("FAIL rand_rt_sel c=%0d: got %b want %b", c, bus.ex_fwd_rt_sel, ert); end
            checks++; if (bus.stall_cycles !== exp_perf()) begin
                errors++; $display("FAIL rand_perf c=%0d: got %0d want %0d", c, bus.stall_cycles, exp_perf()); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_r0_alu();
        test_fwd_priority();
        test_waw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
